// File: rtl/core_ifetch_queue.sv
// Instruction fetch unit: issues sequential word reads over a req/gnt + in-order rvalid bus
// and buffers {pc, inst} pairs in a small FIFO feeding decode with valid/ready.
module core_ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] kill_cnt_q, kill_cnt_d;

    logic [CW:0]   credit;
    logic [31:0]   redir_tgt;
    logic          grant, rsp, kill, push, pop;

    // Credits count both buffered words and in-flight reads, so a push can never overflow.
    assign credit      = {1'b0, count_q} + {1'b0, out_cnt_q};
    assign o_imem_req  = i_rst_n & ~i_redirect & (credit < (CW+1)'(DEPTH))
                         & (out_cnt_q < CW'(MAX_OUT));
    assign o_imem_addr = fetch_pc_q;

    assign grant     = o_imem_req & i_imem_gnt;
    // A response with nothing in flight is a protocol violation and is ignored outright.
    assign rsp       = i_imem_rvalid & (out_cnt_q != '0);
    assign kill      = rsp & (kill_cnt_q != '0);
    assign push      = rsp & ~kill & ~i_redirect;
    assign redir_tgt = {i_redirect_pc[31:2], 2'b00};

    assign o_valid = (count_q != '0) & ~i_redirect;
    assign pop     = o_valid & i_ready;
    assign o_inst  = inst_mem_q[rd_ptr_q];
    assign o_pc    = pc_mem_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_cnt_d  = out_cnt_q + CW'(grant) - CW'(rsp);
        kill_cnt_d = kill_cnt_q;
        if (i_redirect) begin
            // Everything still outstanding after this cycle belongs to the old path.
            fetch_pc_d = redir_tgt;
            resp_pc_d  = redir_tgt;
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
            kill_cnt_d = out_cnt_q - CW'(rsp);
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)  resp_pc_d  = resp_pc_q + 32'd4;
            if (push)  wr_ptr_d   = wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_d   = rd_ptr_q + AW'(1);
            count_d    = count_q + CW'(push) - CW'(pop);
            kill_cnt_d = kill_cnt_q - CW'(kill);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_cnt_q  <= '0;
            kill_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_cnt_q  <= out_cnt_d;
            kill_cnt_q <= kill_cnt_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= resp_pc_q;
                inst_mem_q[wr_ptr_q] <= i_imem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_core_ifetch_queue.sv
// Randomized bench for core_ifetch_queue: the reference model tracks in-flight requests as a
// queue of {addr, stale} and the FIFO as a queue of {pc, inst}, independent of any counters.
module tb_core_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt = 1'b0, rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        o_valid, ready = 1'b0;
    logic [31:0] o_inst, o_pc;

    int checks = 0;
    int errors = 0;

    core_ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_valid(o_valid), .i_ready(ready), .o_inst(o_inst), .o_pc(o_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    fl_t         infl[$];
    ent_t        fifo_m[$];
    logic [31:0] m_fetch = RESET_PC;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit m_req();
        return rst_n && !redirect && (fifo_m.size() + infl.size() < DEPTH) && (infl.size() < MAX_OUT);
    endfunction

    function automatic bit m_valid();
        return rst_n && fifo_m.size() != 0 && !redirect;
    endfunction

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic set_in(input bit g, input bit rv, input bit rdy, input bit rd, input logic [31:0] rpc);
        @(negedge clk);
        gnt         = g;
        rvalid      = rv && infl.size() > 0;
        rdata       = rvalid ? mem(infl[0].addr) : $urandom;
        ready       = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic set_rand(input int pg, input int prv, input int prdy, input int prd);
        set_in($urandom_range(0, 99) < pg, $urandom_range(0, 99) < prv,
               $urandom_range(0, 99) < prdy, $urandom_range(0, 99) < prd, $urandom);
    endtask

    // Advances the reference model by one clock using the inputs currently applied.
    task automatic step();
        bit   req = m_req();
        bit   vld = m_valid();
        fl_t  h;
        ent_t e;
        if (redirect) begin
            fifo_m.delete();
            if (rvalid) h = infl.pop_front();
            foreach (infl[i]) infl[i].stale = 1'b1;
            m_fetch = {redirect_pc[31:2], 2'b00};
        end else begin
            if (vld && ready) e = fifo_m.pop_front();
            if (rvalid) begin
                h = infl.pop_front();
                if (!h.stale) fifo_m.push_back('{h.addr, mem(h.addr)});
            end
            if (req && gnt) begin
                infl.push_back('{m_fetch, 1'b0});
                m_fetch = m_fetch + 32'd4;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        gnt = 0; rvalid = 0; redirect = 0; ready = 0;
        rst_n = 0;
        infl.delete(); fifo_m.delete(); m_fetch = RESET_PC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", o_inst); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", o_pc); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc = RESET_PC;
        bit          seen = 0;
        for (int c = 0; c < 24; c++) begin
            set_in(1, 1, 1, 0, '0);
            checks++; if (imem_req !== m_req()) begin errors++; $display("FAIL stream_req got %b want %b", imem_req, m_req()); end
            if (m_req()) begin checks++; if (imem_addr !== m_fetch) begin errors++; $display("FAIL stream_addr got %h want %h", imem_addr, m_fetch); end end
            checks++; if (o_valid !== m_valid()) begin errors++; $display("FAIL stream_valid got %b want %b", o_valid, m_valid()); end
            if (m_valid()) begin checks++; if ({o_pc, o_inst} !== {fifo_m[0].pc, fifo_m[0].inst}) begin errors++; $display("FAIL stream_head got %h/%h want %h/%h", o_pc, o_inst, fifo_m[0].pc, fifo_m[0].inst); end end
            // Once flowing, decode must see a new word every cycle in address order.
            if (seen || o_valid) begin
                checks++;
                if (o_valid !== 1'b1 || o_pc !== exp_pc || o_inst !== mem(exp_pc)) begin
                    errors++; $display("FAIL stream_seq got v=%b pc=%h want pc=%h", o_valid, o_pc, exp_pc);
                end
                seen = 1; exp_pc += 4;
            end
            step();
        end
        checks++; if (!seen) begin errors++; $display("FAIL stream_never_valid got 0 want 1"); end
    endtask

    task automatic test_backpressure();
        int ngr = 0, npop = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            set_in(1, 1, 0, 0, '0);
            if (imem_req && gnt) ngr++;
            step();
        end
        set_in(0, 0, 0, 0, '0);
        checks++; if (ngr != DEPTH) begin errors++; $display("FAIL bp_grants got %0d want %0d", ngr, DEPTH); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full got %b want 0", imem_req); end
        checks++; if (o_valid !== 1'b1 || o_pc !== RESET_PC) begin errors++; $display("FAIL bp_head got v=%b pc=%h want 1/%h", o_valid, o_pc, RESET_PC); end
        step();
        for (int c = 0; c < 8; c++) begin
            set_in(0, 1, 1, 0, '0);
            if (o_valid) begin
                checks++;
                if (o_pc !== RESET_PC + 32'(4 * npop) || o_inst !== mem(RESET_PC + 32'(4 * npop))) begin
                    errors++; $display("FAIL bp_drain got %h/%h want pc %h", o_pc, o_inst, RESET_PC + 32'(4 * npop));
                end
                npop++;
            end
            step();
        end
        checks++; if (npop != DEPTH) begin errors++; $display("FAIL bp_pops got %0d want %0d", npop, DEPTH); end
    endtask

    task automatic test_gnt_stall();
        logic [31:0] held = RESET_PC + 32'(4 * DEPTH);
        for (int c = 0; c < 5; c++) begin
            set_in(0, 0, 1, 0, '0);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== held) begin
                errors++; $display("FAIL stall_hold got req=%b addr=%h want 1/%h", imem_req, imem_addr, held);
            end
            step();
        end
        set_in(1, 0, 1, 0, '0);
        step();
        set_in(0, 0, 1, 0, '0);
        checks++; if (imem_addr !== held + 32'd4) begin errors++; $display("FAIL stall_advance got %h want %h", imem_addr, held + 32'd4); end
        step();
    endtask

    task automatic test_redirect();
        bit seen_a = 0, seen_v = 0;
        do_reset();
        repeat (2) begin set_in(1, 0, 1, 0, '0); step(); end
        set_in(0, 0, 1, 1, 32'h0000_0103);
        checks++; if (imem_req !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL redir_cycle got req=%b v=%b want 0/0", imem_req, o_valid); end
        step();
        for (int c = 0; c < 20; c++) begin
            set_in(1, 1, 1, 0, '0);
            checks++; if (imem_req !== m_req()) begin errors++; $display("FAIL redir_req got %b want %b", imem_req, m_req()); end
            if (m_req()) begin checks++; if (imem_addr !== m_fetch) begin errors++; $display("FAIL redir_addr got %h want %h", imem_addr, m_fetch); end end
            checks++; if (o_valid !== m_valid()) begin errors++; $display("FAIL redir_valid got %b want %b", o_valid, m_valid()); end
            if (m_valid()) begin checks++; if ({o_pc, o_inst} !== {fifo_m[0].pc, fifo_m[0].inst}) begin errors++; $display("FAIL redir_head got %h/%h want %h/%h", o_pc, o_inst, fifo_m[0].pc, fifo_m[0].inst); end end
            if (imem_req && !seen_a) begin
                seen_a = 1; checks++;
                if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_first_addr got %h want 00000100", imem_addr); end
            end
            if (o_valid && !seen_v) begin
                seen_v = 1; checks++;
                if (o_pc !== 32'h100) begin errors++; $display("FAIL redir_first_pc got %h want 00000100", o_pc); end
            end
            step();
        end
        checks++; if (!seen_v) begin errors++; $display("FAIL redir_timeout got no valid want valid"); end
    endtask

    task automatic test_redirect_pop();
        bit seen_v = 0;
        do_reset();
        repeat (2) begin set_in(1, 0, 0, 0, '0); step(); end
        set_in(0, 1, 0, 0, '0); step();
        set_in(1, 0, 0, 0, '0); step();
        // Head is valid, a response arrives and decode is ready, all in the redirect cycle.
        set_in(0, 1, 1, 1, 32'h0000_0200);
        checks++; if (o_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rpop_cycle got v=%b req=%b want 0/0", o_valid, imem_req); end
        step();
        for (int c = 0; c < 20; c++) begin
            set_in(1, 1, 1, 0, '0);
            checks++; if (imem_req !== m_req()) begin errors++; $display("FAIL rpop_req got %b want %b", imem_req, m_req()); end
            if (m_req()) begin checks++; if (imem_addr !== m_fetch) begin errors++; $display("FAIL rpop_addr got %h want %h", imem_addr, m_fetch); end end
            checks++; if (o_valid !== m_valid()) begin errors++; $display("FAIL rpop_valid got %b want %b", o_valid, m_valid()); end
            if (o_valid && !seen_v) begin
                seen_v = 1; checks++;
                if (o_pc !== 32'h200 || o_inst !== mem(32'h200)) begin errors++; $display("FAIL rpop_first got %h/%h want 00000200", o_pc, o_inst); end
            end
            step();
        end
        checks++; if (!seen_v) begin errors++; $display("FAIL rpop_timeout got no valid want valid"); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            set_rand(70, 60, 70, 4);
            checks++; if (imem_req !== m_req()) begin errors++; $display("FAIL rnd_req cyc %0d got %b want %b", c, imem_req, m_req()); end
            if (m_req()) begin checks++; if (imem_addr !== m_fetch) begin errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", c, imem_addr, m_fetch); end end
            checks++; if (o_valid !== m_valid()) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, o_valid, m_valid()); end
            if (m_valid()) begin checks++; if ({o_pc, o_inst} !== {fifo_m[0].pc, fifo_m[0].inst}) begin errors++; $display("FAIL rnd_head cyc %0d got %h/%h want %h/%h", c, o_pc, o_inst, fifo_m[0].pc, fifo_m[0].inst); end end
            step();
        end
    endtask

    task automatic test_async_reset();
        bit seen_v = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin set_in(1, 1, 0, 0, '0); step(); end
        @(negedge clk);
        gnt = 0; rvalid = 0; ready = 0;
        #1 rst_n = 0;
        #1;
        checks++; if (o_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL areset_out got v=%b req=%b want 0/0", o_valid, imem_req); end
        checks++; if (o_pc !== 32'h0 || o_inst !== 32'h0) begin errors++; $display("FAIL areset_head got %h/%h want 0/0", o_pc, o_inst); end
        infl.delete(); fifo_m.delete(); m_fetch = RESET_PC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 12; c++) begin
            set_in(1, 1, 1, 0, '0);
            checks++; if (imem_req !== m_req()) begin errors++; $display("FAIL areset_req got %b want %b", imem_req, m_req()); end
            if (m_req()) begin checks++; if (imem_addr !== m_fetch) begin errors++; $display("FAIL areset_addr got %h want %h", imem_addr, m_fetch); end end
            checks++; if (o_valid !== m_valid()) begin errors++; $display("FAIL areset_valid got %b want %b", o_valid, m_valid()); end
            if (o_valid && !seen_v) begin
                seen_v = 1; checks++;
                if (o_pc !== RESET_PC) begin errors++; $display("FAIL areset_first_pc got %h want %h", o_pc, RESET_PC); end
            end
            step();
        end
        checks++; if (!seen_v) begin errors++; $display("FAIL areset_timeout got no valid want valid"); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect();
        test_redirect_pop();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
